// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the miniRV pipeline hazard sequencer:
// state encodings, register-index constants and the load-use detector.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_RESUME = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    function automatic logic load_use(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_re1,
        input logic       id_re2
    );
        return ex_is_load && (ex_rd != REG_X0) &&
               ((id_re1 && (id_rs1 == ex_rd)) || (id_re2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage miniRV pipeline, with a pending
// redirect held across data-memory freezes and saturating hazard counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W           = 16,
    parameter bit          RESUME_REDIRECT = 1'b1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             npc_op_i,
    input  logic [31:0]      j_pc_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_re1_i,
    input  logic             id_re2_i,
    input  logic             mem_busy_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o
);

    logic [1:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             lu;
    logic             lu_inc, redir_inc, frz_inc;
    logic [CNT_W-1:0] lu_cnt, redir_cnt, frz_cnt;

    assign lu = load_use(ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_re1_i, id_re2_i);

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        pend_pc_d      = pend_pc_q;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        redirect_o     = 1'b0;
        redirect_pc_o  = 32'd0;
        lu_inc         = 1'b0;
        redir_inc      = 1'b0;
        frz_inc        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy_i) begin
                    {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o} = 4'b1111;
                    if (npc_op_i) begin
                        pend_d    = 1'b1;
                        pend_pc_d = j_pc_i;
                    end
                    state_d = ST_FREEZE;
                end else if (npc_op_i) begin
                    // The ID instruction is wrong-path, so any load-use hazard is moot.
                    redirect_o    = 1'b1;
                    redirect_pc_o = j_pc_i;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    redir_inc     = 1'b1;
                end else if (lu) begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    lu_inc        = 1'b1;
                end
            end
            ST_FREEZE: begin
                {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o} = 4'b1111;
                frz_inc = 1'b1;
                if (npc_op_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = j_pc_i;
                end
                if (!mem_busy_i) begin
                    if (pend_d && RESUME_REDIRECT) begin
                        state_d = ST_RESUME;
                    end else begin
                        state_d = ST_RUN;
                        pend_d  = 1'b0;
                    end
                end
            end
            ST_RESUME: begin
                if (mem_busy_i) begin
                    {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o} = 4'b1111;
                    state_d = ST_FREEZE;
                end else begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = pend_pc_q;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    redir_inc     = 1'b1;
                    pend_d        = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase

        if (cpu_rst) begin
            pc_stall_o     = 1'b0;
            if_id_stall_o  = 1'b0;
            id_ex_stall_o  = 1'b0;
            ex_mem_stall_o = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            redirect_o     = 1'b0;
            redirect_pc_o  = 32'd0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q   <= ST_RUN;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk_i (cpu_clk),
        .rst_i (cpu_rst),
        .en_i  (lu_inc),
        .cnt_o (lu_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk_i (cpu_clk),
        .rst_i (cpu_rst),
        .en_i  (redir_inc),
        .cnt_o (redir_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_frz_cnt (
        .clk_i (cpu_clk),
        .rst_i (cpu_rst),
        .en_i  (frz_inc),
        .cnt_o (frz_cnt)
    );

    // Counters read as zero during reset, like every other output.
    assign lu_stall_cnt_o = cpu_rst ? '0 : lu_cnt;
    assign redirect_cnt_o = cpu_rst ? '0 : redir_cnt;
    assign freeze_cnt_o   = cpu_rst ? '0 : frz_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage miniRV pipeline.
- Inputs:
  - the EX-stage jump decision (npc_op / target from the jump-detect logic);
  - ID/EX register-use information;
  - the data-memory busy flag.
- Drives stall and flush enables for PC, IF/ID, ID/EX and EX/MEM, plus the single PC-redirect command.
- Holds a pending redirect across memory freezes and keeps saturating hazard performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.
- RESUME_REDIRECT, 1, 1 = redirect captured during a freeze is issued on the freeze-exit cycle; 0 = drop it (EX re-presents it).

Ports:
- cpu_clk  input  1  system clock, all state updates on rising edge
- cpu_rst  input  1  synchronous, active-high reset
- npc_op_i  input  1  EX-stage instruction redirects PC (taken branch, JAL, JALR)
- j_pc_i  input  32  EX-stage redirect target
- ex_is_load_i  input  1  EX-stage instruction is a load
- ex_rd_i  input  5  EX-stage destination register
- id_rs1_i  input  5  ID-stage source register 1
- id_rs2_i  input  5  ID-stage source register 2
- id_re1_i  input  1  ID instruction reads rs1
- id_re2_i  input  1  ID instruction reads rs2
- mem_busy_i  input  1  data memory not ready; whole pipe must hold
- pc_stall_o  output  1  PC holds value
- if_id_stall_o  output  1  IF/ID register holds
- id_ex_stall_o  output  1  ID/EX register holds
- ex_mem_stall_o  output  1  EX/MEM register holds
- if_id_flush_o  output  1  IF/ID loads bubble
- id_ex_flush_o  output  1  ID/EX loads bubble
- redirect_o  output  1  PC loads redirect_pc_o at next edge
- redirect_pc_o  output  32  redirect target
- lu_stall_cnt_o  output  CNT_W  load-use stall cycles, saturating
- redirect_cnt_o  output  CNT_W  redirects issued, saturating
- freeze_cnt_o  output  CNT_W  memory-freeze cycles, saturating

Behaviour:
- States: RUN, FREEZE, RESUME (2-bit encoded). Registers: state_q, pend_q, pend_pc_q[31:0], the three counters.
- Reset (cpu_rst=1 at edge): state_q=RUN, pend_q=0, pend_pc_q=0, all counters 0.
  - All outputs are 0 while cpu_rst is high, regardless of the other inputs.
  - Reset in FREEZE or RESUME discards any pending redirect.
- Hazard term: lu = ex_is_load_i & (ex_rd_i!=0) & ((id_re1_i & id_rs1_i==ex_rd_i) | (id_re2_i & id_rs2_i==ex_rd_i)).
- All stall, flush and redirect outputs are combinational from state_q and the current inputs (zero-cycle latency).
- RUN:
  - mem_busy_i=1:
    - pc/if_id/id_ex/ex_mem stalls = 1; flushes = 0; redirect_o = 0.
    - If npc_op_i, capture pend_q=1 and pend_pc_q=j_pc_i.
    - Next state FREEZE.
  - Else npc_op_i=1:
    - redirect_o=1, redirect_pc_o=j_pc_i, if_id_flush_o=1, id_ex_flush_o=1; stalls 0.
    - Redirect takes priority over lu: the ID instruction is wrong-path.
    - redirect_cnt += 1.
  - Else lu=1:
    - pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1; EX/MEM advances.
    - lu_stall_cnt += 1.
    - Exactly one bubble, since the load leaves EX next cycle.
  - Else all outputs 0.
- FREEZE:
  - All four stalls = 1; flushes = 0; redirect_o = 0; freeze_cnt += 1.
  - npc_op_i=1 while frozen (re)captures pend_q and pend_pc_q (latest value wins).
  - When mem_busy_i=0:
    - go to RESUME if pend_q & RESUME_REDIRECT;
    - else go to RUN and clear pend_q.
  - The exit cycle itself still drives full stall.
- RESUME (one cycle):
  - redirect_o=1, redirect_pc_o=pend_pc_q, both flushes = 1; redirect_cnt += 1; clear pend_q.
  - Next state RUN.
  - If mem_busy_i=1 in RESUME: stalls override, and redirect and flushes are suppressed. Keep pend_q, go to FREEZE.
- redirect_pc_o = 0 whenever redirect_o = 0.
- Counters saturate at all-ones and never wrap.
- Input sampling is not required outside the captured pending registers.

Decomposition:
- Shared defines header holds:
  - state encodings (ST_RUN=2'd0, ST_FREEZE=2'd1, ST_RESUME=2'd2);
  - the x0 register index constant.
- One natural sub-module: sat_counter (CNT_W, enable, synchronous reset), instantiated three times.

Test Plan:
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=5, id_rs1=5, id_re1=1.
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle; lu_stall_cnt 0->1. With ex_rd=0 or id_re1=0, all outputs stay 0.
- Redirect beats load-use:
  - Stimulus: npc_op=1, j_pc=0x0000_0040, with the same lu condition.
  - Response: redirect_o=1, redirect_pc=0x40, both flushes=1, no stalls; lu_stall_cnt unchanged, redirect_cnt=1.
- Freeze with pending redirect:
  - Stimulus: mem_busy=1 for 3 cycles while npc_op=1, j_pc=0x100.
  - Response:
    - all stalls=1 for those 3 cycles and on the exit cycle;
    - next cycle redirect_o=1, redirect_pc=0x100, both flushes=1;
    - freeze_cnt=3, redirect_cnt=1.
- Re-freeze in RESUME:
  - Stimulus: mem_busy rises in the RESUME cycle.
  - Response: full stall, no redirect; redirect issued once after mem_busy falls; redirect_cnt increments only once.
- Reset mid-freeze:
  - Stimulus: cpu_rst=1 during FREEZE with pend_q=1.
  - Response: outputs 0 while reset is high; after release, no redirect issued, state RUN, counters 0.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive load-use cycles.
  - Response: lu_stall_cnt holds at 15.
